// File: rtl/xor_mem_pkg.sv
// Shared types and defaults for the XOR memory front-end.
// State enum, address-width helper and default geometry.
package xor_mem_pkg;

  localparam int XM_PORTS = 4;
  localparam int XM_DEPTH = 512;
  localparam int XM_WIDTH = 64;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_t;

  // bits needed to represent n (at least 1)
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((n >> r) != 0) r++;
    return r;
  endfunction

endpackage

// File: rtl/xor_mem_conflict_arbiter.sv
// Same-cycle write-write conflict resolution.
// One winner per address, priority rotated from ptr.
module xor_mem_conflict_arbiter
  import xor_mem_pkg::*;
#(
  parameter int PORTS = XM_PORTS,
  parameter int AW    = 9,
  parameter int PW    = 2
) (
  input  logic [PORTS-1:0]    valid,
  input  logic [PORTS-1:0]    wr,
  input  logic [PORTS*AW-1:0] addr,
  input  logic [PW-1:0]       ptr,
  output logic [PORTS-1:0]    wr_grant
);

  function automatic int rank(input int x, input int base);
    return (x + PORTS - base) % PORTS;
  endfunction

  always_comb begin
    wr_grant = valid & wr;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        if (q != p && valid[q] && wr[q] &&
            addr[q*AW +: AW] == addr[p*AW +: AW] &&
            rank(q, int'(ptr)) < rank(p, int'(ptr)))
          wr_grant[p] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xor_memory_port_scheduler.sv
// Front-end scheduler for the multi-port XOR memory: zero sweep,
// conflict/RAW gating, registered memory drive. Macro: XOR_SCHED_RR_EN.
module xor_memory_port_scheduler
  import xor_mem_pkg::*;
#(
  parameter int PORTS        = XM_PORTS,
  parameter int DEPTH        = XM_DEPTH,
  parameter int WIDTH        = XM_WIDTH,
  parameter int LOG2_DEPTH   = log2(DEPTH - 1),
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            req_valid,
  output logic [PORTS-1:0]            req_ready,
  input  logic [PORTS-1:0]            req_wr,
  input  logic [PORTS*LOG2_DEPTH-1:0] req_addr,
  input  logic [PORTS*WIDTH-1:0]      req_d,
  output logic [PORTS-1:0]            rsp_valid,
  output logic [PORTS*WIDTH-1:0]      rsp_q,
  output logic [PORTS-1:0]            mem_wr,
  output logic [PORTS*LOG2_DEPTH-1:0] mem_addr,
  output logic [PORTS*WIDTH-1:0]      mem_d,
  input  logic [PORTS*WIDTH-1:0]      mem_q,
  output logic                        init_done
);

  localparam int AW    = LOG2_DEPTH;
  localparam int PW    = log2(PORTS - 1);
  localparam int SWEEP = DEPTH / PORTS;
  localparam logic [AW-1:0] K_LAST = AW'(SWEEP - 1);

  sched_state_t state_q, state_d;
  logic [AW-1:0]                  k_q;
  logic [PORTS-1:0]               hz_vld_q;
  logic [PORTS*AW-1:0]            hz_addr_q;
  logic [READ_LATENCY:0][PORTS-1:0] pipe_q;
  logic [PW-1:0]                  ptr;
  logic [PORTS-1:0]               wr_grant;
  logic [PORTS-1:0]               raw_hit;
  logic [PORTS-1:0]               gnt;

  xor_mem_conflict_arbiter #(
    .PORTS(PORTS),
    .AW   (AW),
    .PW   (PW)
  ) u_arb (
    .valid   (req_valid),
    .wr      (req_wr),
    .addr    (req_addr),
    .ptr     (ptr),
    .wr_grant(wr_grant)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    raw_hit   = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        if (hz_vld_q[q] &&
            hz_addr_q[q*AW +: AW] == req_addr[p*AW +: AW])
          raw_hit[p] = 1'b1;
      end
    end
    unique case (state_q)
      INIT: if (k_q == K_LAST) state_d = RUN;
      RUN:  req_ready = req_valid &
                        ((req_wr & wr_grant) | (~req_wr & ~raw_hit));
      default: ;
    endcase
  end

  assign gnt       = req_valid & req_ready;
  assign init_done = (state_q == RUN);
  assign rsp_valid = pipe_q[READ_LATENCY];
  assign rsp_q     = mem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      k_q       <= '0;
      mem_wr    <= '0;
      mem_addr  <= '0;
      mem_d     <= '0;
      hz_vld_q  <= '0;
      hz_addr_q <= '0;
      pipe_q    <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= {pipe_q[READ_LATENCY-1:0], gnt & ~req_wr};
      if (state_q == INIT) begin
        k_q      <= k_q + 1'b1;
        mem_wr   <= '1;
        mem_d    <= '0;
        hz_vld_q <= '0;
        for (int p = 0; p < PORTS; p++)
          mem_addr[p*AW +: AW] <= AW'(int'(k_q) * PORTS + p);
      end else begin
        mem_wr   <= gnt & req_wr;
        hz_vld_q <= gnt & req_wr;
        for (int p = 0; p < PORTS; p++) begin
          if (gnt[p]) begin
            mem_addr[p*AW +: AW]    <= req_addr[p*AW +: AW];
            mem_d[p*WIDTH +: WIDTH] <= req_d[p*WIDTH +: WIDTH];
            hz_addr_q[p*AW +: AW]   <= req_addr[p*AW +: AW];
          end
        end
      end
    end
  end

`ifdef XOR_SCHED_RR_EN
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PORTS-1:0] lost, won;

  // next pointer follows the top-ranked winner of any conflict
  always_comb begin
    lost  = {PORTS{state_q == RUN}} & req_valid & req_wr & ~wr_grant;
    won   = '0;
    ptr_d = ptr_q;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        if (lost[q] && gnt[p] && req_wr[p] &&
            req_addr[q*AW +: AW] == req_addr[p*AW +: AW])
          won[p] = 1'b1;
      end
    end
    for (int r = PORTS - 1; r >= 0; r--) begin
      if (won[(int'(ptr_q) + r) % PORTS])
        ptr_d = PW'(((int'(ptr_q) + r) % PORTS + 1) % PORTS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_xor_memory_port_scheduler.sv
// Bench for xor_memory_port_scheduler with a behavioural memory
// and a request-level reference model.
module tb_xor_memory_port_scheduler;

  localparam int P   = 4;
  localparam int D   = 512;
  localparam int W   = 64;
  localparam int AW  = 9;
  localparam int RL  = 1;
  localparam int NSW = D / P;
  localparam int NT  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [P-1:0]    req_valid, req_ready, req_wr, rsp_valid, mem_wr;
  logic [P*AW-1:0] req_addr, mem_addr;
  logic [P*W-1:0]  req_d, rsp_q, mem_d, mem_q;
  logic            init_done;

  xor_memory_port_scheduler #(
    .PORTS(P), .DEPTH(D), .WIDTH(W), .LOG2_DEPTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q),
    .init_done(init_done)
  );

  // memory: registered read of pre-write contents
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      mem_q[p*W +: W] <= mem[mem_addr[p*AW +: AW]];
      if (mem_wr[p]) mem[mem_addr[p*AW +: AW]] <= mem_d[p*W +: W];
    end
  end

  typedef struct {
    int port;
    int due;
    logic [W-1:0] data;
  } rsp_t;

  typedef struct packed {
    logic [P-1:0]    v;
    logic [P-1:0]    w;
    logic [P*AW-1:0] a;
    logic [P*W-1:0]  d;
    logic [P-1:0]    rdy;
  } row_t;

  int checks = 0;
  int errors = 0;

  logic         s_rst;
  logic [P-1:0] s_v, s_w;
  logic [AW-1:0] s_a [P];
  logic [W-1:0]  s_d [P];

  bit  m_known = 0, m_in_rst = 0;
  int  m_cnt = 0, m_cyc = 0, m_ptr = 0;
  logic [W-1:0]  ref_mem [D];
  logic [AW-1:0] prev_wset [$];
  logic [P-1:0]  prev_wgnt = '0;
  logic [AW-1:0] prev_a [P];
  logic [W-1:0]  prev_d [P];
  rsp_t          rq [$];
  logic [P-1:0]  last_gnt = '0, dut_rdy;
  row_t          tbl [NT];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, m_cyc, act, exp);
    end
  endtask

  function automatic int rank(input int x);
    return (x - m_ptr + P) % P;
  endfunction

  task automatic tick();
    logic [P-1:0] er;
    logic [W-1:0] ed;
    bit run, ev;
    rsp_t e;
`ifdef XOR_SCHED_RR_EN
    int best;
`endif
    @(negedge clk);
    rst_n = s_rst;
    req_valid = s_v;
    req_wr = s_w;
    for (int p = 0; p < P; p++) begin
      req_addr[p*AW +: AW] = s_a[p];
      req_d[p*W +: W] = s_d[p];
    end
    #1;
    dut_rdy = req_ready;
    er = '0;
    run = m_known && !m_in_rst && m_cnt >= NSW;
    if (run) begin
      for (int p = 0; p < P; p++) begin
        if (s_v[p]) begin
          er[p] = 1'b1;
          if (s_w[p]) begin
            for (int q = 0; q < P; q++)
              if (q != p && s_v[q] && s_w[q] && s_a[q] == s_a[p] &&
                  rank(q) < rank(p)) er[p] = 1'b0;
          end else begin
            foreach (prev_wset[i])
              if (prev_wset[i] == s_a[p]) er[p] = 1'b0;
          end
        end
      end
    end
    if (m_known && m_in_rst) begin
      chk("rst_ready", W'(req_ready), '0);
      chk("rst_rsp_valid", W'(rsp_valid), '0);
      chk("rst_mem_wr", W'(mem_wr), '0);
      chk("rst_init_done", W'(init_done), '0);
      chk("rst_mem_addr", W'(mem_addr), '0);
      for (int p = 0; p < P; p++) chk("rst_mem_d", mem_d[p*W +: W], '0);
    end else if (m_known) begin
      chk("init_done", W'(init_done), W'(m_cnt >= NSW));
      chk("req_ready", W'(req_ready), W'(er));
      if (m_cnt <= NSW) begin
        chk("sweep_wr", W'(mem_wr), W'({P{1'b1}}));
        for (int p = 0; p < P; p++) begin
          chk("sweep_addr", W'(mem_addr[p*AW +: AW]), W'((m_cnt - 1) * P + p));
          chk("sweep_d", mem_d[p*W +: W], '0);
        end
      end else begin
        chk("mem_wr", W'(mem_wr), W'(prev_wgnt));
        for (int p = 0; p < P; p++) begin
          if (prev_wgnt[p]) begin
            chk("mem_addr", W'(mem_addr[p*AW +: AW]), W'(prev_a[p]));
            chk("mem_d", mem_d[p*W +: W], prev_d[p]);
          end
        end
      end
      for (int p = 0; p < P; p++) begin
        ev = 0;
        ed = '0;
        foreach (rq[i])
          if (rq[i].port == p && rq[i].due == m_cyc) begin
            ev = 1;
            ed = rq[i].data;
          end
        chk("rsp_valid", W'(rsp_valid[p]), W'(ev));
        if (ev) chk("rsp_q", rsp_q[p*W +: W], ed);
      end
    end
    while (rq.size() > 0 && rq[0].due <= m_cyc) void'(rq.pop_front());
    if (!s_rst) begin
      m_known = 1;
      m_in_rst = 1;
      m_cnt = 0;
      m_ptr = 0;
      rq.delete();
      prev_wset.delete();
      prev_wgnt = '0;
      last_gnt = '0;
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
    end else if (m_known) begin
      m_in_rst = 0;
      m_cnt++;
      last_gnt = er;
      for (int p = 0; p < P; p++)
        if (er[p] && !s_w[p]) begin
          e.port = p;
          e.due = m_cyc + 1 + RL;
          e.data = ref_mem[s_a[p]];
          rq.push_back(e);
        end
      prev_wset.delete();
      for (int p = 0; p < P; p++)
        if (er[p] && s_w[p]) begin
          ref_mem[s_a[p]] = s_d[p];
          prev_wset.push_back(s_a[p]);
        end
      prev_wgnt = er & s_w;
      prev_a = s_a;
      prev_d = s_d;
`ifdef XOR_SCHED_RR_EN
      best = -1;
      for (int p = 0; p < P; p++)
        if (er[p] && s_w[p])
          for (int q = 0; q < P; q++)
            if (s_v[q] && s_w[q] && !er[q] && s_a[q] == s_a[p])
              if (best < 0 || rank(p) < rank(best)) best = p;
      if (best >= 0) m_ptr = (best + 1) % P;
`endif
    end
    m_cyc++;
  endtask

  task automatic idle(input int n);
    s_v = '0;
    repeat (n) tick();
  endtask

  task automatic reset_and_sweep();
    s_v = '0;
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    while (m_cnt <= NSW) tick();
  endtask

  initial begin
    int n;
    logic [P-1:0] exp_w;
    tbl[0] = '{4'b0101, 4'b0101, {9'd0, 9'd5, 9'd0, 9'd5},
               {64'd0, 64'h2222, 64'd0, 64'h1111}, 4'b0001};
    tbl[1] = '{4'b0100, 4'b0100, {9'd0, 9'd5, 9'd0, 9'd0},
               {64'd0, 64'h2222, 64'd0, 64'd0}, 4'b0100};
    tbl[2] = '{4'b0000, 4'b0000, '0, '0, 4'b0000};
    tbl[3] = '{4'b0010, 4'b0010, {9'd0, 9'd0, 9'd9, 9'd0},
               {64'd0, 64'd0, 64'hAA, 64'd0}, 4'b0010};
    tbl[4] = '{4'b1000, 4'b0000, {9'd9, 9'd0, 9'd0, 9'd0}, '0, 4'b0000};
    tbl[5] = '{4'b1000, 4'b0000, {9'd9, 9'd0, 9'd0, 9'd0}, '0, 4'b1000};
    tbl[6] = '{4'b0011, 4'b0001, {9'd0, 9'd0, 9'd3, 9'd3},
               {64'd0, 64'd0, 64'd0, 64'h55}, 4'b0011};
    tbl[7] = '{4'b0001, 4'b0000, {9'd0, 9'd0, 9'd0, 9'd5}, '0, 4'b0001};
    tbl[8] = '{4'b0000, 4'b0000, '0, '0, 4'b0000};
    tbl[9] = '{4'b0000, 4'b0000, '0, '0, 4'b0000};

    for (int i = 0; i < D; i++) mem[i] = {$urandom, $urandom};
    s_rst = 1'b0;
    s_v = '1;
    s_w = '0;
    for (int p = 0; p < P; p++) begin
      s_a[p] = '0;
      s_d[p] = '0;
    end
    repeat (3) tick();

    // reads held through the sweep are first accepted with init_done
    s_rst = 1'b1;
    while (m_cnt <= NSW) tick();
    chk("first_accept", W'(dut_rdy), W'({P{1'b1}}));
    idle(3);

    for (int i = 0; i < NT; i++) begin
      s_v = tbl[i].v;
      s_w = tbl[i].w;
      for (int p = 0; p < P; p++) begin
        s_a[p] = tbl[i].a[p*AW +: AW];
        s_d[p] = tbl[i].d[p*W +: W];
      end
      tick();
      chk("tbl_ready", W'(dut_rdy), W'(tbl[i].rdy));
    end
    idle(3);

    // reset mid-sweep restarts the full sweep
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    while (m_cnt < 61) tick();
    chk("mid_sweep_done", W'(init_done), '0);
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
    chk("restart_len", W'(n), W'(NSW + 1));
    idle(2);

    // every port writes address 7 for four cycles
    reset_and_sweep();
    for (int i = 0; i < 4; i++) begin
      s_v = '1;
      s_w = '1;
      for (int p = 0; p < P; p++) begin
        s_a[p] = 9'd7;
        s_d[p] = W'(i * 16 + p);
      end
      tick();
`ifdef XOR_SCHED_RR_EN
      exp_w = P'(1 << i);
`else
      exp_w = P'(1);
`endif
      chk("conflict_winner", W'(dut_rdy), W'(exp_w));
    end
    idle(1);
    s_v = 4'b0010;
    s_w = '0;
    s_a[1] = 9'd7;
    tick();
    idle(3);

    // randomized traffic; stalled requests are held unchanged
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!(s_v[p] && !last_gnt[p])) begin
          s_v[p] = ($urandom % 3) != 0;
          s_w[p] = $urandom % 2;
          s_a[p] = AW'($urandom % 12);
          s_d[p] = {$urandom, $urandom};
        end
      end
      tick();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
